audio_stream_player: RTL and testbench
======================================

Name: audio_stream_player

Overview:
- Parametrised successor to the single-channel UART-to-DAC streaming path.
- Takes the byte stream from rxuart and assembles interleaved multi-channel PCM frames of configurable width, buffering them in an internal circular frame store.
- Releases frames at a fixed sample rate to the sigma-delta DACs.
- Adds prime/underrun playback control, partial-frame resync on line gaps, overrun detection, and hysteretic host flow control (CTS).

Parameters:
CLK_FREQ, 12_000_000, system clock frequency in Hz
SAMPLE_RATE, 11_025, output frame rate in Hz; DIV = CLK_FREQ/SAMPLE_RATE (integer division)
SAMPLE_BITS, 16, bits per sample; multiple of 8, range 8..24; BYTES = SAMPLE_BITS/8
CHANNELS, 2, interleaved channels per frame, range 1..4
DEPTH, 1024, frame store depth in frames; power of 2, >= 4
PRIME_LEVEL, DEPTH/2, fill level at which playback starts
LOW_MARK, DEPTH/8, fill level at or below which CTS re-asserts
HIGH_MARK, DEPTH-DEPTH/8, fill level at or above which CTS drops
GAP_CYCLES, 4096, idle clocks after which a partial frame is discarded

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous reset, active low
rx_byte  in  8  received byte from rxuart
rx_received  in  1  one-cycle strobe; rx_byte valid this cycle
sample_out  out  CHANNELS*SAMPLE_BITS  current frame; channel 0 in LSBs; each sample two's complement
sample_strobe  out  1  one-cycle pulse in the cycle sample_out takes a new value
playing  out  1  1 while in PLAY state
fill  out  $clog2(DEPTH)+1  frames currently stored, 0..DEPTH
cts  out  1  1 = host may send
underrun  out  1  one-cycle pulse: tick found store empty during PLAY
overrun  out  1  one-cycle pulse: completed frame dropped because store full

Behaviour:
- Reset (reset_n=0 at a clock edge) clears the following. sample_out=0, sample_strobe=0, playing=0, fill=0, cts=1, underrun=0, overrun=0, rate counter=DIV-1, byte/channel indices=0, partial frame discarded, gap timer=0. Reset mid-frame or mid-play simply abandons all state.
- Byte assembly: bytes arrive LSB-first within a sample, channel 0 first. A byte index (0..BYTES-1) and a channel index (0..CHANNELS-1) advance on each rx_received. Both wrap to 0 after the last byte of the last channel, and a write request is raised that cycle with the completed frame.
- Write acceptance: a frame is written if fill<DEPTH, or if a pop occurs in the same cycle. Otherwise the frame is dropped and overrun pulses in the next cycle. Indices wrap regardless, so framing is preserved.
- Gap resync: the gap timer counts clocks since the last rx_received while a frame is partial (any index nonzero). On reaching GAP_CYCLES it zeroes both indices, discards the partial data and resets to 0. The timer is held at 0 when no frame is partial.
- Store: DEPTH x (CHANNELS*SAMPLE_BITS) RAM with write/read pointers of $clog2(DEPTH)+1 bits. fill = wptr - rptr (registered). A simultaneous write and pop leaves fill unchanged.
- Rate tick: a free-running down-counter runs from DIV-1 to 0. An internal tick is asserted when it reaches 0, so the first tick falls DIV clocks after reset release and ticks continue every DIV clocks thereafter, independent of state.
- Playback FSM:
  - IDLE: sample_out held at 0, no pops. Moves to PLAY on the first clock where fill >= PRIME_LEVEL.
  - PLAY, tick with fill>0: pop one frame. sample_out gets that frame one clock after the tick, with sample_strobe high in that same cycle.
  - PLAY, tick with fill==0: underrun pulses the next cycle, sample_out is set to 0 with sample_strobe, and the FSM returns to IDLE.
- CTS hysteresis: cts goes to 0 on the clock after fill >= HIGH_MARK. It returns to 1 on the clock after fill <= LOW_MARK, and otherwise holds its value.
- Width rules: fill comparisons are unsigned. No arithmetic is applied to the samples; they pass through bit-exact.

Optional Feature:
Macro AUDIO_STREAM_STATS_EN.
- Defined: adds outputs underrun_count[15:0] and overrun_count[15:0]. Each increments on its event pulse, saturates at 16'hFFFF, and clears on reset.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
Bench config for all scenarios: CLK_FREQ=1000, SAMPLE_RATE=100 (DIV=10), SAMPLE_BITS=16, CHANNELS=2, DEPTH=16, PRIME_LEVEL=8, LOW_MARK=2, HIGH_MARK=14, GAP_CYCLES=50.
1. Framing/prime: send 8 frames, frame k = bytes {k,0x11,k,0x22} -> playing=1 after the 8th frame. The first strobe after the next tick shows sample_out=0x22k_11k (ch1=0x22kk, ch0=0x11kk), and successive frames follow on consecutive strobes, 10 clocks apart.
2. Underrun: prime 8 frames, then stop sending -> 8 strobed frames, then underrun pulse, sample_out=0, playing=0, fill=0.
3. Overrun: with playback not primed (PRIME_LEVEL forced to 17 via parameter override), send 17 frames -> fill=16, exactly one overrun pulse, and the 17th frame is absent on readout.
4. CTS hysteresis: fill 0->14 -> cts=0 at 14. Drain to 3 -> cts still 0. At fill=2 -> cts=1.
5. Gap resync: send 3 bytes, idle 60 clocks, then send 4 bytes {0xAA,0xBB,0xCC,0xDD} -> fill=1 and the stored frame reads 0xDDCC_BBAA.
6. Reset mid-play: assert reset_n=0 for 1 clock during PLAY with fill=5 -> fill=0, cts=1, playing=0, sample_out=0, and the next complete frame is stored correctly.

Source files
------------

// File: rtl/audio_stream_player.sv
// Byte-stream to multi-channel PCM player: assembles frames from rxuart bytes, buffers
// them in a circular frame store and releases one per sample tick. AUDIO_STREAM_STATS_EN adds event counters.
module audio_stream_player #(
    parameter int CLK_FREQ    = 12_000_000,
    parameter int SAMPLE_RATE = 11_025,
    parameter int SAMPLE_BITS = 16,
    parameter int CHANNELS    = 2,
    parameter int DEPTH       = 1024,
    parameter int PRIME_LEVEL = DEPTH / 2,
    parameter int LOW_MARK    = DEPTH / 8,
    parameter int HIGH_MARK   = DEPTH - DEPTH / 8,
    parameter int GAP_CYCLES  = 4096
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [7:0]                      rx_byte,
    input  logic                            rx_received,
    output logic [CHANNELS*SAMPLE_BITS-1:0] sample_out,
    output logic                            sample_strobe,
    output logic                            playing,
    output logic [$clog2(DEPTH):0]          fill,
    output logic                            cts,
    output logic                            underrun,
    output logic                            overrun
`ifdef AUDIO_STREAM_STATS_EN
    ,
    output logic [15:0]                     underrun_count,
    output logic [15:0]                     overrun_count
`endif
);

    localparam int DIV   = CLK_FREQ / SAMPLE_RATE;
    localparam int BYTES = SAMPLE_BITS / 8;
    localparam int FW    = CHANNELS * SAMPLE_BITS;
    localparam int LANES = CHANNELS * BYTES;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW    = $clog2(GAP_CYCLES + 1);

    localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES - 1);
    localparam logic [CW-1:0] CH_LAST   = CW'(CHANNELS - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] DEPTH_C   = PW'(DEPTH);
    localparam logic [PW:0]   PRIME_C   = (PW + 1)'(PRIME_LEVEL);
    localparam logic [PW:0]   LOW_C     = (PW + 1)'(LOW_MARK);
    localparam logic [PW:0]   HIGH_C    = (PW + 1)'(HIGH_MARK);

    typedef enum logic {IDLE, PLAY} state_t;

    logic [BW-1:0] byte_idx_reg;
    logic [CW-1:0] ch_idx_reg;
    logic [LW-1:0] lane_idx;
    logic [GW-1:0] gap_reg;
    logic [DW-1:0] rate_reg;
    logic [PW-1:0] wptr_reg, rptr_reg, wptr_next, rptr_next, fill_reg;
    logic [FW-1:0] wr_data;
    logic [FW-1:0] mem [DEPTH];
    logic [FW-1:0] sample_reg;
    logic          partial, wr_req, wr_en, tick, pop;
    logic          strobe_reg, underrun_reg, overrun_reg, cts_reg;
    state_t        state_reg;

    assign partial  = (byte_idx_reg != '0) || (ch_idx_reg != '0);
    assign wr_req   = rx_received && (byte_idx_reg == BYTE_LAST) && (ch_idx_reg == CH_LAST);
    assign tick     = (rate_reg == '0);
    assign pop      = (state_reg == PLAY) && tick && (fill_reg != '0);
    // A pop in the same cycle frees a slot, so a full store can still take the new frame.
    assign wr_en    = wr_req && ((fill_reg != DEPTH_C) || pop);
    assign lane_idx = LW'(ch_idx_reg) * LW'(BYTES) + LW'(byte_idx_reg);

    // Each byte lane holds its byte until the frame completes; the last lane comes straight from the line.
    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : g_lane
        if (gi < LANES - 1) begin : g_hold
            logic [7:0] byte_reg;
            always_ff @(posedge clk) begin
                if (rx_received && (lane_idx == LW'(gi)))
                    byte_reg <= rx_byte;
            end
            assign wr_data[gi*8 +: 8] = byte_reg;
        end else begin : g_last
            assign wr_data[gi*8 +: 8] = rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            byte_idx_reg <= '0;
            ch_idx_reg   <= '0;
            gap_reg      <= '0;
        end else if (rx_received) begin
            gap_reg <= '0;
            if (byte_idx_reg == BYTE_LAST) begin
                byte_idx_reg <= '0;
                ch_idx_reg   <= (ch_idx_reg == CH_LAST) ? '0 : ch_idx_reg + 1'b1;
            end else begin
                byte_idx_reg <= byte_idx_reg + 1'b1;
            end
        end else if (partial) begin
            if (gap_reg == GAP_LAST) begin
                byte_idx_reg <= '0;
                ch_idx_reg   <= '0;
                gap_reg      <= '0;
            end else begin
                gap_reg <= gap_reg + 1'b1;
            end
        end else begin
            gap_reg <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || tick)
            rate_reg <= DIV_LAST;
        else
            rate_reg <= rate_reg - 1'b1;
    end

    always_comb begin
        wptr_next = wr_en ? wptr_reg + 1'b1 : wptr_reg;
        rptr_next = pop   ? rptr_reg + 1'b1 : rptr_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            fill_reg <= '0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
            fill_reg <= wptr_next - rptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr_reg[AW-1:0]] <= wr_data;
    end

    // Playback FSM; the store read doubles as the sample_out register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            strobe_reg   <= 1'b0;
            underrun_reg <= 1'b0;
            sample_reg   <= '0;
        end else begin
            strobe_reg   <= 1'b0;
            underrun_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if ({1'b0, fill_reg} >= PRIME_C)
                        state_reg <= PLAY;
                end
                PLAY: begin
                    if (tick) begin
                        strobe_reg <= 1'b1;
                        if (pop) begin
                            sample_reg <= mem[rptr_reg[AW-1:0]];
                        end else begin
                            sample_reg   <= '0;
                            underrun_reg <= 1'b1;
                            state_reg    <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cts_reg     <= 1'b1;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= wr_req && !wr_en;
            if ({1'b0, fill_reg} >= HIGH_C)
                cts_reg <= 1'b0;
            else if ({1'b0, fill_reg} <= LOW_C)
                cts_reg <= 1'b1;
        end
    end

`ifdef AUDIO_STREAM_STATS_EN
    logic [15:0] underrun_count_reg, overrun_count_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            underrun_count_reg <= '0;
            overrun_count_reg  <= '0;
        end else begin
            if (underrun_reg && (underrun_count_reg != 16'hFFFF))
                underrun_count_reg <= underrun_count_reg + 1'b1;
            if (overrun_reg && (overrun_count_reg != 16'hFFFF))
                overrun_count_reg <= overrun_count_reg + 1'b1;
        end
    end

    assign underrun_count = underrun_count_reg;
    assign overrun_count  = overrun_count_reg;
`endif

    assign sample_out    = sample_reg;
    assign sample_strobe = strobe_reg;
    assign playing       = (state_reg == PLAY);
    assign fill          = fill_reg;
    assign cts           = cts_reg;
    assign underrun      = underrun_reg;
    assign overrun       = overrun_reg;

endmodule

// File: tb/tb_audio_stream_player.sv
// Scoreboard bench for audio_stream_player: queue-based reference model predicts strobed frames and status.
module tb_audio_stream_player;

    localparam int DIV   = 10;
    localparam int DEPTH = 16;
    localparam int PRIME = 8;
    localparam int LOW   = 2;
    localparam int HIGH  = 14;
    localparam int GAP   = 50;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_byte;
    logic        rx_received;

    logic [31:0] sample_out;
    logic        sample_strobe, playing, cts, underrun, overrun;
    logic [4:0]  fill;

    logic [31:0] s2_sample_out;
    logic        s2_strobe, s2_playing, s2_cts, s2_underrun, s2_overrun;
    logic [4:0]  s2_fill;

    always #5 clk = ~clk;

    audio_stream_player #(
        .CLK_FREQ(1000), .SAMPLE_RATE(100), .SAMPLE_BITS(16), .CHANNELS(2), .DEPTH(DEPTH),
        .PRIME_LEVEL(PRIME), .LOW_MARK(LOW), .HIGH_MARK(HIGH), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rx_byte(rx_byte), .rx_received(rx_received),
        .sample_out(sample_out), .sample_strobe(sample_strobe), .playing(playing),
        .fill(fill), .cts(cts), .underrun(underrun), .overrun(overrun)
    );

    audio_stream_player #(
        .CLK_FREQ(1000), .SAMPLE_RATE(100), .SAMPLE_BITS(16), .CHANNELS(2), .DEPTH(DEPTH),
        .PRIME_LEVEL(17), .LOW_MARK(LOW), .HIGH_MARK(HIGH), .GAP_CYCLES(GAP)
    ) dut_noprime (
        .clk(clk), .reset_n(reset_n), .rx_byte(rx_byte), .rx_received(rx_received),
        .sample_out(s2_sample_out), .sample_strobe(s2_strobe), .playing(s2_playing),
        .fill(s2_fill), .cts(s2_cts), .underrun(s2_underrun), .overrun(s2_overrun)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        und;
    } ev_t;

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0;
    int          ov2_cnt = 0;

    // Reference model state
    logic [31:0] m_q[$];
    logic [7:0]  m_part[$];
    ev_t         sb[$];
    int          m_gap, m_k;
    bit          m_play, m_cts, m_under, m_over;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: frame store is a queue, the line is a byte list, ticks fall every DIV-th clock after reset.
    initial begin : model
        int          f0;
        bit          tick, popped;
        logic [31:0] fr;
        ev_t         ev;
        m_gap = 0; m_k = 0; m_play = 0; m_cts = 1; m_under = 0; m_over = 0;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_q.delete(); m_part.delete(); sb.delete();
                m_gap = 0; m_k = 0; m_play = 0; m_cts = 1; m_under = 0; m_over = 0;
            end else begin
                m_k++;
                tick    = (m_k % DIV) == 0;
                f0      = m_q.size();
                m_under = 0;
                m_over  = 0;
                popped  = 0;
                if (m_play && tick) begin
                    if (f0 > 0) begin
                        ev.data = m_q.pop_front(); ev.und = 1'b0; popped = 1;
                    end else begin
                        ev.data = '0; ev.und = 1'b1; m_under = 1; m_play = 0;
                    end
                    sb.push_back(ev);
                end else if (!m_play && f0 >= PRIME) begin
                    m_play = 1;
                end
                if (rx_received) begin
                    m_part.push_back(rx_byte);
                    m_gap = 0;
                    if (m_part.size() == 4) begin
                        fr = {m_part[3], m_part[2], m_part[1], m_part[0]};
                        m_part.delete();
                        if (f0 < DEPTH || popped) m_q.push_back(fr);
                        else m_over = 1;
                    end
                end else if (m_part.size() > 0) begin
                    m_gap++;
                    if (m_gap == GAP) begin
                        m_part.delete(); m_gap = 0;
                    end
                end
                if (f0 >= HIGH) m_cts = 0;
                else if (f0 <= LOW) m_cts = 1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT strobes and checks status every cycle.
    initial begin : monitor
        ev_t ev;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("sample_strobe", sample_strobe, sb.size() != 0);
                if (sb.size() != 0) begin
                    ev = sb.pop_front();
                    if (sample_strobe) begin
                        chk("sample_out", sample_out, ev.data);
                        chk("underrun_on_strobe", underrun, ev.und);
                    end
                end
                chk("fill", fill, m_q.size());
                chk("playing", playing, m_play);
                chk("cts", cts, m_cts);
                chk("underrun", underrun, m_under);
                chk("overrun", overrun, m_over);
            end
        end
    end

    initial begin : ov2_counter
        forever begin
            @(negedge clk);
            if (s2_overrun) ov2_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_received = 1'b1;
        @(negedge clk);
        rx_received = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] f);
        for (int i = 0; i < 4; i++) send_byte(f[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_fill", fill, 0);
        chk("rst_cts", cts, 1);
        chk("rst_playing", playing, 0);
        chk("rst_sample_out", sample_out, 0);
        chk("rst_strobe", sample_strobe, 0);
    endtask

    task automatic wait_fill(input int target, input string name);
        int n = 0;
        while (m_q.size() != target && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < 400), 1);
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_strobe && n < 200);
        chk("strobe_wait", (n < 200), 1);
    endtask

    initial begin : stimulus
        int          n;
        int          guard;
        logic [7:0]  k8;
        reset_n = 1'b0;
        rx_received = 1'b0;
        rx_byte = 8'h00;
        @(negedge clk);
        mon_en = 1;
        do_reset();

        // Framing and prime
        for (int k = 1; k <= 8; k++) begin
            k8 = 8'(k);
            send_frame({8'h22, k8, 8'h11, k8});
        end
        idle(1);
        chk("s1_playing", playing, 1);
        wait_strobe(n);
        chk("s1_first", sample_out, 32'h2201_1101);
        wait_strobe(n);
        chk("s1_second", sample_out, 32'h2202_1102);
        chk("s1_spacing", n, DIV);
        idle(100);

        // Underrun after draining a primed store
        do_reset();
        for (int k = 0; k < 8; k++) send_frame($urandom);
        idle(120);
        chk("s2_playing", playing, 0);
        chk("s2_fill", fill, 0);
        chk("s2_sample", sample_out, 0);

        // Overrun on the never-primed instance, then on the playing one
        do_reset();
        ov2_cnt = 0;
        for (int k = 0; k < 17; k++) send_frame($urandom);
        idle(2);
        chk("s3_fill", s2_fill, 16);
        chk("s3_overruns", ov2_cnt, 1);
        chk("s3_playing", s2_playing, 0);
        chk("s3_cts", s2_cts, 0);
        chk("s3_sample", s2_sample_out, 0);
        chk("s3_strobe", s2_strobe, 0);
        chk("s3_underrun", s2_underrun, 0);
        do_reset();
        for (int k = 0; k < 30; k++) send_frame($urandom);
        idle(200);

        // CTS hysteresis
        do_reset();
        guard = 0;
        while (m_q.size() < 14 && guard < 40) begin
            send_frame($urandom);
            guard++;
        end
        idle(1);
        chk("s4_cts_high", cts, 0);
        wait_fill(3, "s4_wait3");
        chk("s4_cts_hold", cts, 0);
        wait_fill(2, "s4_wait2");
        idle(1);
        chk("s4_cts_low", cts, 1);
        idle(100);

        // Gap resync
        do_reset();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        idle(60);
        send_frame(32'hDDCC_BBAA);
        idle(1);
        chk("s5_fill", fill, 1);
        for (int k = 0; k < 7; k++) send_frame($urandom);
        wait_strobe(n);
        chk("s5_frame", sample_out, 32'hDDCC_BBAA);
        idle(100);

        // Reset mid-play
        do_reset();
        for (int k = 0; k < 8; k++) send_frame($urandom);
        wait_fill(5, "s6_wait5");
        chk("s6_playing", playing, 1);
        do_reset();
        send_frame(32'h1234_5678);
        idle(1);
        chk("s6_fill", fill, 1);
        for (int k = 0; k < 7; k++) send_frame($urandom);
        wait_strobe(n);
        chk("s6_frame", sample_out, 32'h1234_5678);

        // Random traffic with gaps, long pauses and occasional resets
        for (int i = 0; i < 500; i++) begin
            n = $urandom_range(0, 99);
            if (n < 70)      send_byte(8'($urandom));
            else if (n < 95) idle($urandom_range(1, 8));
            else if (n < 99) idle($urandom_range(45, 60));
            else             do_reset();
        end
        idle(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
